// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// FSM state type and the hard-wired zero register index.
package mem_stage_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: store byte enables / lane replication, misalign
// detection, and load lane select with sign or zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be       = 4'b1111;
        wdata    = store_data;
        misalign = 1'b0;
        case (size)
            MEM_SIZE_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_SIZE_H: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{store_data[15:0]}};
                misalign = addr_lo[0];
            end
            // Reserved encoding behaves as a word access.
            default: begin
                be       = 4'b1111;
                wdata    = store_data;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (ld_size)
            MEM_SIZE_B: load_data = ld_unsigned ? {24'd0, ld_byte}
                                                : {{24{ld_byte[7]}}, ld_byte};
            MEM_SIZE_H: load_data = ld_unsigned ? {16'd0, ld_half}
                                                : {{16{ld_half[15]}}, ld_half};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EXEC results, runs data-memory accesses over a
// req/ack handshake with a bounded wait, and emits registered WB results.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_unsigned,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_write_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_write_reg,
    output logic [31:0]       wb_write_data,
    output logic              exc_misalign,
    output logic              exc_bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    mem_state_t state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;

    logic        ld_is_load;
    logic        ld_unsigned;
    logic        ld_reg_write;
    logic [1:0]  ld_size;
    logic [1:0]  ld_addr_lo;
    logic [4:0]  ld_write_reg;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_load_data;

    logic accept;
    logic is_mem;
    logic timeout;

    assign accept  = ex_valid & ex_ready;
    assign is_mem  = ex_mem_read | ex_mem_write;
    assign timeout = (state == BUSY) & ~dmem_ack & (wait_cnt == CNT_W'(MAX_WAIT - 1));

    mem_align u_align (
        .size        (ex_mem_size),
        .addr_lo     (ex_alu_result[1:0]),
        .store_data  (ex_store_data),
        .be          (al_be),
        .wdata       (al_wdata),
        .misalign    (al_misalign),
        .ld_size     (ld_size),
        .ld_addr_lo  (ld_addr_lo),
        .ld_unsigned (ld_unsigned),
        .rdata       (dmem_rdata),
        .load_data   (al_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem && !al_misalign) state_nxt = BUSY;
            BUSY:    if (dmem_ack || timeout)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex_ready = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            ld_is_load    <= 1'b0;
            ld_unsigned   <= 1'b0;
            ld_reg_write  <= 1'b0;
            ld_size       <= '0;
            ld_addr_lo    <= '0;
            ld_write_reg  <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            wb_write_data <= '0;
            exc_misalign  <= 1'b0;
            exc_bus       <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_write_reg <= ex_write_reg;
                        if (!is_mem) begin
                            wb_valid      <= 1'b1;
                            wb_reg_write  <= ex_reg_write && (ex_write_reg != REG_ZERO);
                            wb_write_data <= ex_alu_result;
                        end else if (al_misalign) begin
                            wb_valid      <= 1'b1;
                            exc_misalign  <= 1'b1;
                            wb_write_data <= ex_alu_result;
                        end else begin
                            dmem_req     <= 1'b1;
                            dmem_we      <= ~ex_mem_read;
                            dmem_addr    <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            dmem_wdata   <= al_wdata;
                            dmem_be      <= ex_mem_read ? 4'b1111 : al_be;
                            ld_is_load   <= ex_mem_read;
                            ld_unsigned  <= ex_mem_unsigned;
                            ld_reg_write <= ex_reg_write;
                            ld_size      <= ex_mem_size;
                            ld_addr_lo   <= ex_alu_result[1:0];
                            ld_write_reg <= ex_write_reg;
                            wait_cnt     <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Returning to IDLE on completion blocks a second pulse for this op.
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_reg_write  <= ld_is_load && ld_reg_write && (ld_write_reg != REG_ZERO);
                        wb_write_reg  <= ld_write_reg;
                        wb_write_data <= ld_is_load ? al_load_data : '0;
                    end else if (timeout) begin
                        dmem_req      <= 1'b0;
                        wb_valid      <= 1'b1;
                        exc_bus       <= 1'b1;
                        wb_write_reg  <= ld_write_reg;
                        wb_write_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with a short bus timeout.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic        ex_reg_write;
    logic [4:0]  ex_write_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        exc_misalign;
    logic        exc_bus;

    int unsigned n_checks;
    int unsigned n_fail;

    mem_stage #(.ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_alu_result   (ex_alu_result),
        .ex_store_data   (ex_store_data),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_size     (ex_mem_size),
        .ex_mem_unsigned (ex_mem_unsigned),
        .ex_reg_write    (ex_reg_write),
        .ex_write_reg    (ex_write_reg),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_write_reg    (wb_write_reg),
        .wb_write_data   (wb_write_data),
        .exc_misalign    (exc_misalign),
        .exc_bus         (exc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge, then withdraw it.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rdst);
        ex_valid        = 1'b1;
        ex_mem_read     = rd;
        ex_mem_write    = wr;
        ex_mem_size     = size;
        ex_mem_unsigned = uns;
        ex_alu_result   = addr;
        ex_store_data   = sdata;
        ex_reg_write    = 1'b1;
        ex_write_reg    = rdst;
        tick();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Stay BUSY for n cycles, acknowledging in the last one.
    task automatic ack_after(input int unsigned n, input logic [31:0] rdata);
        for (int unsigned i = 0; i < n; i++) begin
            check_eq("busy_ready", ex_ready, 0);
            check_eq("busy_req", dmem_req, 1);
            check_eq("busy_wb", wb_valid, 0);
            if (i == n - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
        end
        dmem_ack = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [31:0] exp);
        issue(1'b1, 1'b0, size, uns, addr, 32'h0, 5'd9);
        ack_after(1, rdata);
        check_eq({tag, "_valid"}, wb_valid, 1);
        check_eq({tag, "_data"}, wb_write_data, exp);
        check_eq({tag, "_we"}, wb_reg_write, 1);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = '0;
        ex_mem_unsigned = 1'b0; ex_reg_write = 1'b0; ex_write_reg = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", ex_ready, 1);
        check_eq("rst_req", dmem_req, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_data", wb_write_data, 0);
        check_eq("rst_exc", {exc_misalign, exc_bus}, 0);
        rst_n = 1'b1;
        tick();

        // Non-memory op, latency 1
        issue(1'b0, 1'b0, MEM_SIZE_W, 1'b0, 32'h1234, 32'h0, 5'd5);
        check_eq("alu_valid", wb_valid, 1);
        check_eq("alu_reg", wb_write_reg, 5);
        check_eq("alu_data", wb_write_data, 32'h1234);
        check_eq("alu_we", wb_reg_write, 1);
        check_eq("alu_req", dmem_req, 0);
        tick();
        check_eq("alu_pulse", wb_valid, 0);

        // lb 0x103 with ack in third BUSY cycle
        issue(1'b1, 1'b0, MEM_SIZE_B, 1'b0, 32'h103, 32'h0, 5'd7);
        check_eq("lb_we", dmem_we, 0);
        check_eq("lb_addr", dmem_addr, 32'h100);
        check_eq("lb_be", dmem_be, 4'b1111);
        ack_after(3, 32'h80FF_0000);
        check_eq("lb_valid", wb_valid, 1);
        check_eq("lb_data", wb_write_data, 32'hFFFF_FF80);
        check_eq("lb_reg", wb_write_reg, 7);
        check_eq("lb_wreg", wb_reg_write, 1);
        check_eq("lb_ready", ex_ready, 1);
        check_eq("lb_req_drop", dmem_req, 0);
        tick();
        check_eq("lb_pulse", wb_valid, 0);

        load_case("lbu", MEM_SIZE_B, 1'b1, 32'h103, 32'h80FF_0000, 32'h0000_0080);
        load_case("lb1", MEM_SIZE_B, 1'b0, 32'h101, 32'h0000_7F00, 32'h0000_007F);
        load_case("lh", MEM_SIZE_H, 1'b0, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
        load_case("lhu", MEM_SIZE_H, 1'b1, 32'h102, 32'h8001_1234, 32'h0000_8001);
        load_case("lw", MEM_SIZE_W, 1'b0, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_case("rsvd", 2'b11, 1'b0, 32'h108, 32'h1357_9BDF, 32'h1357_9BDF);

        // sh 0x202
        issue(1'b0, 1'b1, MEM_SIZE_H, 1'b0, 32'h202, 32'h0000_ABCD, 5'd3);
        check_eq("sh_we", dmem_we, 1);
        check_eq("sh_addr", dmem_addr, 32'h200);
        check_eq("sh_be", dmem_be, 4'b1100);
        check_eq("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        ack_after(1, 32'h0);
        check_eq("sh_valid", wb_valid, 1);
        check_eq("sh_wreg", wb_reg_write, 0);
        tick();

        // sb 0x301
        issue(1'b0, 1'b1, MEM_SIZE_B, 1'b0, 32'h301, 32'h1234_565A, 5'd3);
        check_eq("sb_be", dmem_be, 4'b0010);
        check_eq("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        ack_after(2, 32'h0);
        check_eq("sb_wreg", wb_reg_write, 0);
        tick();

        // read&write both set behaves as a load
        issue(1'b1, 1'b1, MEM_SIZE_W, 1'b0, 32'h400, 32'h1111_1111, 5'd4);
        check_eq("rw_we", dmem_we, 0);
        ack_after(1, 32'hCAFE_F00D);
        check_eq("rw_data", wb_write_data, 32'hCAFE_F00D);
        check_eq("rw_wreg", wb_reg_write, 1);
        tick();

        // Misaligned word load
        issue(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h6, 32'h0, 5'd8);
        check_eq("mis_req", dmem_req, 0);
        check_eq("mis_valid", wb_valid, 1);
        check_eq("mis_exc", exc_misalign, 1);
        check_eq("mis_wreg", wb_reg_write, 0);
        check_eq("mis_ready", ex_ready, 1);
        tick();
        check_eq("mis_pulse", exc_misalign, 0);

        // Misaligned half store
        issue(1'b0, 1'b1, MEM_SIZE_H, 1'b0, 32'h203, 32'h0, 5'd8);
        check_eq("mish_req", dmem_req, 0);
        check_eq("mish_exc", exc_misalign, 1);
        tick();

        // Load to $0 is never written
        issue(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h10, 32'h0, 5'd0);
        ack_after(1, 32'h5555_AAAA);
        check_eq("r0_valid", wb_valid, 1);
        check_eq("r0_wreg", wb_reg_write, 0);
        tick();

        // ALU op to $0 is never written
        issue(1'b0, 1'b0, MEM_SIZE_W, 1'b0, 32'h99, 32'h0, 5'd0);
        check_eq("alu_r0_wreg", wb_reg_write, 0);
        tick();

        // Stray ack while IDLE
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_eq("idle_ack_wb", wb_valid, 0);

        // Timeout after 4 BUSY cycles; late ack ignored
        issue(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h20, 32'h0, 5'd6);
        for (int unsigned i = 0; i < 4; i++) begin
            check_eq("to_req", dmem_req, 1);
            check_eq("to_wb", wb_valid, 0);
            tick();
        end
        check_eq("to_req_drop", dmem_req, 0);
        check_eq("to_valid", wb_valid, 1);
        check_eq("to_exc", exc_bus, 1);
        check_eq("to_wreg", wb_reg_write, 0);
        check_eq("to_ready", ex_ready, 1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check_eq("late_ack_wb", wb_valid, 0);
        check_eq("late_ack_exc", exc_bus, 0);
        check_eq("late_ack_req", dmem_req, 0);

        // Reset while BUSY
        issue(1'b1, 1'b0, MEM_SIZE_W, 1'b0, 32'h40, 32'h0, 5'd2);
        check_eq("rb_req_pre", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rb_req", dmem_req, 0);
        check_eq("rb_ready", ex_ready, 1);
        dmem_ack = 1'b1;
        tick();
        check_eq("rb_wb", wb_valid, 0);
        rst_n = 1'b1;
        dmem_ack = 1'b0;
        tick();
        check_eq("rb_wb_after", wb_valid, 0);
        check_eq("rb_req_after", dmem_req, 0);

        // Back-to-back op after reset still works
        issue(1'b0, 1'b0, MEM_SIZE_W, 1'b0, 32'hFEED_0001, 32'h0, 5'd31);
        check_eq("post_rst_data", wb_write_data, 32'hFEED_0001);
        check_eq("post_rst_reg", wb_write_reg, 31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
